// File: rtl/reorder_buffer_if.sv
// Bundle of issue, CDB, operand-lookup and commit signals between the core and the reorder buffer.
// The ROB itself uses the slave modport; decoder/CDB/regfile side uses master.
interface reorder_buffer_if #(
  parameter int ROB_WIDTH_BIT = 4
);
  logic                     issue_en;
  logic [1:0]               issue_type;
  logic [4:0]               issue_rd;
  logic [31:0]              issue_pc;
  logic                     full;
  logic [ROB_WIDTH_BIT-1:0] tail_id;

  logic                     cdb_en;
  logic [ROB_WIDTH_BIT-1:0] cdb_id;
  logic [31:0]              cdb_value;
  logic                     cdb_mispredict;

  logic [ROB_WIDTH_BIT-1:0] q1_id;
  logic [ROB_WIDTH_BIT-1:0] q2_id;
  logic                     q1_ready;
  logic                     q2_ready;
  logic [31:0]              q1_value;
  logic [31:0]              q2_value;

  logic                     commit_en;
  logic [4:0]               commit_reg;
  logic [ROB_WIDTH_BIT-1:0] commit_id;
  logic [31:0]              commit_value;
  logic                     store_commit;
  logic                     flush;
  logic [31:0]              flush_pc;

  modport master (
    output issue_en, issue_type, issue_rd, issue_pc,
    output cdb_en, cdb_id, cdb_value, cdb_mispredict,
    output q1_id, q2_id,
    input  full, tail_id, q1_ready, q2_ready, q1_value, q2_value,
    input  commit_en, commit_reg, commit_id, commit_value,
    input  store_commit, flush, flush_pc
  );

  modport slave (
    input  issue_en, issue_type, issue_rd, issue_pc,
    input  cdb_en, cdb_id, cdb_value, cdb_mispredict,
    input  q1_id, q2_id,
    output full, tail_id, q1_ready, q2_ready, q1_value, q2_value,
    output commit_en, commit_reg, commit_id, commit_value,
    output store_commit, flush, flush_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order retirement, CDB capture, commit-time misprediction flush.
// Optional macro ROB_BYPASS_EN forwards a same-cycle CDB result onto the operand lookups.
module reorder_buffer #(
  parameter int ROB_WIDTH_BIT = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  reorder_buffer_if.slave  rob
);
  localparam int DEPTH = 1 << ROB_WIDTH_BIT;
  localparam logic [ROB_WIDTH_BIT:0] DEPTH_CNT = (ROB_WIDTH_BIT + 1)'(DEPTH);

  typedef logic [ROB_WIDTH_BIT-1:0] id_t;

  typedef enum logic [1:0] {
    T_REG    = 2'd0,
    T_STORE  = 2'd1,
    T_BRANCH = 2'd2,
    T_RSVD   = 2'd3
  } rob_type_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } rob_state_e;

  logic [DEPTH-1:0]       busy_q;
  logic [DEPTH-1:0]       ready_q;
  logic [DEPTH-1:0]       mis_q;
  rob_type_e              type_q  [DEPTH];
  logic [4:0]             rd_q    [DEPTH];
  logic [31:0]            value_q [DEPTH];

  id_t                    head_q;
  id_t                    tail_q;
  logic [ROB_WIDTH_BIT:0] count_q;
  rob_state_e             state_q;
  rob_state_e             state_d;

  logic                   commit_en_q;
  logic [4:0]             commit_reg_q;
  id_t                    commit_id_q;
  logic [31:0]            commit_value_q;
  logic                   store_commit_q;
  logic [31:0]            flush_pc_q;

  logic                   full;
  logic                   issue_ok;
  logic                   commit_ok;
  logic                   cdb_ok;
  logic                   head_mispredict;
  rob_type_e              issue_type;

  assign full = (count_q == DEPTH_CNT);

  // The entry PC is not kept: a mispredicted branch's CDB value already carries the restart target.
  always_comb begin
    issue_ok        = 1'b0;
    commit_ok       = 1'b0;
    cdb_ok          = 1'b0;
    head_mispredict = 1'b0;
    issue_type      = (rob.issue_type == T_RSVD) ? T_REG : rob_type_e'(rob.issue_type);
    if (state_q == ST_RUN) begin
      issue_ok        = rob.issue_en && !full;
      commit_ok       = busy_q[head_q] && ready_q[head_q];
      cdb_ok          = rob.cdb_en && busy_q[rob.cdb_id];
      head_mispredict = commit_ok && (type_q[head_q] == T_BRANCH) && mis_q[head_q];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (head_mispredict) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= ST_RUN;
      busy_q         <= '0;
      ready_q        <= '0;
      mis_q          <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_en_q    <= 1'b0;
      commit_reg_q   <= '0;
      commit_id_q    <= '0;
      commit_value_q <= '0;
      store_commit_q <= 1'b0;
      flush_pc_q     <= '0;
    end else if (rdy_in) begin
      state_q        <= state_d;
      commit_en_q    <= 1'b0;
      commit_reg_q   <= '0;
      commit_id_q    <= '0;
      commit_value_q <= '0;
      store_commit_q <= 1'b0;
      flush_pc_q     <= '0;
      if (state_q == ST_FLUSH) begin
        busy_q  <= '0;
        ready_q <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (commit_ok) begin
          busy_q[head_q]  <= 1'b0;
          ready_q[head_q] <= 1'b0;
          head_q          <= head_q + id_t'(1);
          case (type_q[head_q])
            T_STORE:  store_commit_q <= 1'b1;
            T_BRANCH: if (mis_q[head_q]) flush_pc_q <= value_q[head_q];
            default: begin
              commit_en_q    <= 1'b1;
              commit_reg_q   <= rd_q[head_q];
              commit_id_q    <= head_q;
              commit_value_q <= value_q[head_q];
            end
          endcase
        end
        if (cdb_ok) begin
          ready_q[rob.cdb_id] <= 1'b1;
          value_q[rob.cdb_id] <= rob.cdb_value;
          mis_q[rob.cdb_id]   <= rob.cdb_mispredict;
        end
        if (issue_ok) begin
          busy_q[tail_q]  <= 1'b1;
          ready_q[tail_q] <= 1'b0;
          mis_q[tail_q]   <= 1'b0;
          type_q[tail_q]  <= issue_type;
          rd_q[tail_q]    <= rob.issue_rd;
          tail_q          <= tail_q + id_t'(1);
        end
        count_q <= count_q + (ROB_WIDTH_BIT + 1)'(issue_ok) - (ROB_WIDTH_BIT + 1)'(commit_ok);
      end
    end
  end

  logic        q1_ready;
  logic        q2_ready;
  logic [31:0] q1_value;
  logic [31:0] q2_value;

  always_comb begin
    q1_ready = busy_q[rob.q1_id] && ready_q[rob.q1_id];
    q2_ready = busy_q[rob.q2_id] && ready_q[rob.q2_id];
    q1_value = q1_ready ? value_q[rob.q1_id] : 32'h0;
    q2_value = q2_ready ? value_q[rob.q2_id] : 32'h0;
`ifdef ROB_BYPASS_EN
    if (rob.cdb_en && (rob.cdb_id == rob.q1_id)) begin
      q1_ready = 1'b1;
      q1_value = rob.cdb_value;
    end
    if (rob.cdb_en && (rob.cdb_id == rob.q2_id)) begin
      q2_ready = 1'b1;
      q2_value = rob.cdb_value;
    end
`else
    // Decoder snoops the CDB itself, so only registered entry state is visible here.
`endif
  end

  assign rob.full         = full;
  assign rob.tail_id      = tail_q;
  assign rob.q1_ready     = q1_ready;
  assign rob.q2_ready     = q2_ready;
  assign rob.q1_value     = q1_value;
  assign rob.q2_value     = q2_value;
  assign rob.commit_en    = commit_en_q;
  assign rob.commit_reg   = commit_reg_q;
  assign rob.commit_id    = commit_id_q;
  assign rob.commit_value = commit_value_q;
  assign rob.store_commit = store_commit_q;
  assign rob.flush        = (state_q == ST_FLUSH);
  assign rob.flush_pc     = flush_pc_q;
endmodule
